// File: rtl/reg_writeback_unit.sv
// Write-side companion of register_file: queues ALU/load results in order, retires one per cycle,
// and offers a youngest-wins bypass lookup over pending writes.
module reg_writeback_unit #(
  parameter int ADDR  = 5,
  parameter int BUS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                         reloj_cucu,
  input  logic                         reset,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [ADDR-1:0]              ld_addr,
  input  logic [BUS_W-1:0]             ld_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR-1:0]              alu_addr,
  input  logic [BUS_W-1:0]             alu_data,
  output logic                         r_write,
  output logic [ADDR-1:0]              rd_addr,
  output logic [BUS_W-1:0]             rd_w_data,
  input  logic [ADDR-1:0]              rs_addr,
  input  logic [ADDR-1:0]              rt_addr,
  output logic                         rs_fwd_hit,
  output logic [BUS_W-1:0]             rs_fwd_data,
  output logic                         rt_fwd_hit,
  output logic [BUS_W-1:0]             rt_fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR-1:0]  r_q_addr [DEPTH];
  logic [BUS_W-1:0] r_q_data [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_wr;
  logic [ADDR-1:0]  r_rd_addr;
  logic [BUS_W-1:0] r_rd_data;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [ADDR-1:0]  w_push_addr;
  logic [BUS_W-1:0] w_push_data;
  logic [PW-1:0]    w_idx;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = (r_count != '0);
  assign ld_ready  = !w_full;
  assign alu_ready = !w_full && !ld_valid;

  // Writes to register 0 still complete the handshake but are discarded here.
  always_comb begin
    w_push      = 1'b0;
    w_push_addr = ld_addr;
    w_push_data = ld_data;
    if (ld_valid && ld_ready) begin
      w_push = (ld_addr != '0);
    end else if (alu_valid && alu_ready) begin
      w_push      = (alu_addr != '0);
      w_push_addr = alu_addr;
      w_push_data = alu_data;
    end
  end

  always_ff @(posedge reloj_cucu or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_addr[i] <= '0;
        r_q_data[i] <= '0;
      end
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_wr      <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) begin
        r_q_addr[r_wptr] <= w_push_addr;
        r_q_data[r_wptr] <= w_push_data;
        r_wptr           <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_wr      <= 1'b1;
        r_rd_addr <= r_q_addr[r_rptr];
        r_rd_data <= r_q_data[r_rptr];
        r_rptr    <= r_rptr + 1'b1;
      end else begin
        r_wr <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Scan oldest to youngest so later matches override: output register first, then head to tail.
  always_comb begin
    rs_fwd_hit  = r_wr && (r_rd_addr == rs_addr) && (rs_addr != '0);
    rs_fwd_data = rs_fwd_hit ? r_rd_data : '0;
    rt_fwd_hit  = r_wr && (r_rd_addr == rt_addr) && (rt_addr != '0);
    rt_fwd_data = rt_fwd_hit ? r_rd_data : '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr + PW'(k);
      if ((CW'(k) < r_count) && (r_q_addr[w_idx] == rs_addr) && (rs_addr != '0)) begin
        rs_fwd_hit  = 1'b1;
        rs_fwd_data = r_q_data[w_idx];
      end
      if ((CW'(k) < r_count) && (r_q_addr[w_idx] == rt_addr) && (rt_addr != '0)) begin
        rt_fwd_hit  = 1'b1;
        rt_fwd_data = r_q_data[w_idx];
      end
    end
  end

  assign r_write   = r_wr;
  assign rd_addr   = r_rd_addr;
  assign rd_w_data = r_rd_data;
  assign count     = r_count;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: expected writes are queued on acceptance and
// checked in order by an independent monitor on the register-file write port.
module tb_reg_writeback_unit;

  localparam int ADDR  = 5;
  localparam int BUS_W = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             ld_valid, alu_valid;
  logic             ld_ready, alu_ready;
  logic [ADDR-1:0]  ld_addr, alu_addr, rs_addr, rt_addr, rd_addr;
  logic [BUS_W-1:0] ld_data, alu_data, rd_w_data, rs_fwd_data, rt_fwd_data;
  logic             r_write, rs_fwd_hit, rt_fwd_hit;
  logic [2:0]       count;

  int n_checks = 0;
  int n_pass   = 0;
  int m_count  = 0;
  logic [ADDR+BUS_W-1:0] exp_q [$];

  reg_writeback_unit #(.ADDR(ADDR), .BUS_W(BUS_W), .DEPTH(DEPTH)) dut (
    .reloj_cucu(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .r_write(r_write), .rd_addr(rd_addr), .rd_w_data(rd_w_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_fwd_hit(rs_fwd_hit), .rs_fwd_data(rs_fwd_data),
    .rt_fwd_hit(rt_fwd_hit), .rt_fwd_data(rt_fwd_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!reset && r_write) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got reg %0d data 0x%08h expected none", rd_addr, rd_w_data);
      end else begin
        logic [ADDR+BUS_W-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rd_addr), 32'(e[ADDR+BUS_W-1:BUS_W]));
        chk("wr_data", rd_w_data, e[BUS_W-1:0]);
      end
    end
  end

  // One clock of stimulus: entered and left 1ns after a rising edge.
  task automatic cycle(input logic lv, input logic [ADDR-1:0] la, input logic [BUS_W-1:0] ldd,
                       input logic av, input logic [ADDR-1:0] aa, input logic [BUS_W-1:0] ad);
    logic e_ld_rdy, e_alu_rdy;
    int push, pop;
    ld_valid = lv;  ld_addr = la;  ld_data = ldd;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    @(negedge clk);
    e_ld_rdy  = (m_count != DEPTH);
    e_alu_rdy = e_ld_rdy && !lv;
    chk("ld_ready", 32'(ld_ready), 32'(e_ld_rdy));
    chk("alu_ready", 32'(alu_ready), 32'(e_alu_rdy));
    chk("count", 32'(count), 32'(m_count));
    push = 0;
    if (lv && e_ld_rdy) begin
      if (la != '0) begin exp_q.push_back({la, ldd}); push = 1; end
    end else if (av && e_alu_rdy) begin
      if (aa != '0) begin exp_q.push_back({aa, ad}); push = 1; end
    end
    pop = (m_count > 0) ? 1 : 0;
    m_count = m_count + push - pop;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    ld_valid = 1'b0; alu_valid = 1'b0;
    ld_addr = '0; alu_addr = '0; ld_data = '0; alu_data = '0;
    rs_addr = '0; rt_addr = '0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_r_write", 32'(r_write), 0);
    chk("rst_rs_hit", 32'(rs_fwd_hit), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Single write latency
    cycle(1'b1, 5'd5, 32'h0000_00AA, 1'b0, '0, '0);      // accepted at edge N
    chk("lat_N_r_write", 32'(r_write), 0);
    idle(1);                                              // edge N+1
    chk("lat_N1_r_write", 32'(r_write), 1);
    chk("lat_N1_rd_addr", 32'(rd_addr), 5);
    chk("lat_N1_rd_data", rd_w_data, 32'h0000_00AA);
    idle(1);                                              // edge N+2
    chk("lat_N2_r_write", 32'(r_write), 0);
    chk("lat_N2_rd_addr_hold", 32'(rd_addr), 5);

    // Arbitration: load wins, ALU follows next cycle
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    cycle(1'b0, '0, '0, 1'b1, 5'd4, 32'h22);
    idle(3);

    // Register 0 drop
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
    rs_addr = 5'd0;
    chk("r0_count", 32'(count), 0);
    chk("r0_rs_hit", 32'(rs_fwd_hit), 0);
    idle(2);
    chk("r0_no_write", 32'(r_write), 0);

    // Sustained traffic from both sources
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
      n_checks++;
      if (count <= 3'(DEPTH)) n_pass++;
      else $display("FAIL count_bound: got %0d expected <= %0d", count, DEPTH);
    end
    idle(3);

    // Bypass, youngest wins
    cycle(1'b1, 5'd10, 32'hA, 1'b0, '0, '0);
    cycle(1'b1, 5'd11, 32'hB, 1'b0, '0, '0);
    cycle(1'b1, 5'd7,  32'h1, 1'b0, '0, '0);
    rs_addr = 5'd7; rt_addr = 5'd11; #1;
    chk("byp_q_rs_hit", 32'(rs_fwd_hit), 1);
    chk("byp_q_rs_data", rs_fwd_data, 32'h1);
    chk("byp_out_rt_hit", 32'(rt_fwd_hit), 1);
    chk("byp_out_rt_data", rt_fwd_data, 32'hB);
    cycle(1'b1, 5'd7,  32'h2, 1'b0, '0, '0);
    rt_addr = 5'd10; #1;
    chk("byp_young_rs_hit", 32'(rs_fwd_hit), 1);
    chk("byp_young_rs_data", rs_fwd_data, 32'h2);
    chk("byp_miss_rt_hit", 32'(rt_fwd_hit), 0);
    chk("byp_miss_rt_data", rt_fwd_data, 0);
    idle(1);
    chk("byp_last_rs_data", rs_fwd_data, 32'h2);
    idle(1);
    chk("byp_done_rs_hit", 32'(rs_fwd_hit), 0);
    chk("byp_done_rs_data", rs_fwd_data, 0);
    idle(2);

    // Reset mid-operation
    cycle(1'b1, 5'd1, 32'hC1, 1'b0, '0, '0);
    cycle(1'b1, 5'd2, 32'hC2, 1'b0, '0, '0);
    cycle(1'b1, 5'd3, 32'hC3, 1'b0, '0, '0);
    ld_valid = 1'b0;
    rs_addr = 5'd3; rt_addr = 5'd2;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_r_write", 32'(r_write), 0);
    chk("mid_rst_rd_addr", 32'(rd_addr), 0);
    chk("mid_rst_rd_data", rd_w_data, 0);
    chk("mid_rst_rs_hit", 32'(rs_fwd_hit), 0);
    chk("mid_rst_rt_hit", 32'(rt_fwd_hit), 0);
    exp_q.delete();
    m_count = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);
    chk("post_rst_r_write", 32'(r_write), 0);

    chk("drain_outstanding", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Write-side companion of register_file: collects results from the ALU and the load unit and drives the register file's single write port (r_write / rd_addr / rd_w_data).
- Buffers up to DEPTH pending writes in an in-order queue and retires one per cycle.
- Exposes a bypass lookup on rs_addr / rt_addr so decode sees results that are pending in the queue but not yet written.

Parameters:
ADDR, 5, register address width (2**ADDR registers; register 0 hardwired to zero)
BUS_W, 32, data width
DEPTH, 4, pending-write queue depth (power of two, >= 2)

Ports:
reloj_cucu  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
ld_valid  in  1  load unit result valid
ld_ready  out  1  load result accepted this cycle when ld_valid && ld_ready
ld_addr  in  ADDR  load destination register
ld_data  in  BUS_W  load result
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
alu_addr  in  ADDR  ALU destination register
alu_data  in  BUS_W  ALU result
r_write  out  1  register-file write enable (registered)
rd_addr  out  ADDR  register-file write address (registered)
rd_w_data  out  BUS_W  register-file write data (registered)
rs_addr  in  ADDR  bypass lookup address A
rt_addr  in  ADDR  bypass lookup address B
rs_fwd_hit  out  1  pending write to rs_addr exists
rs_fwd_data  out  BUS_W  youngest pending data for rs_addr (0 when no hit)
rt_fwd_hit  out  1  same for rt_addr
rt_fwd_data  out  BUS_W  same for rt_addr
count  out  $clog2(DEPTH+1)  number of queued entries (excludes the output register)

Behaviour:
- Reset (asynchronous, active-high): queue emptied, count=0, r_write=0, rd_addr=0, rd_w_data=0. Both fwd_hit outputs read 0. Entries pending at reset are dropped, never written.
- Ready rules (combinational):
  - ld_ready = !full.
  - alu_ready = !full && !ld_valid. The load unit has fixed priority.
  - At most one enqueue per cycle.
  - ready does not depend on a same-cycle pop: when full, the source stalls one cycle even though the head is leaving.
- Enqueue: on an accepted handshake, {addr, data} is written at the tail and count increments.
  - Exception: addr==0 completes the handshake (ready honoured) but nothing is enqueued and count is unchanged.
- Drain: on every edge where count>0, the head is popped into the output registers.
  - r_write=1, rd_addr=head.addr, rd_w_data=head.data.
  - If count==0 at that edge, r_write=0; rd_addr and rd_w_data hold their last value.
- Latency:
  - Result accepted at edge N into an empty queue is popped at edge N+1.
  - r_write is high for exactly one cycle, between edges N+1 and N+2, and the register file captures it at edge N+2.
  - Sustained throughput is 1 write per cycle.
- Push and pop on the same edge: count unchanged, order preserved (FIFO).
- Pointers wrap modulo DEPTH.
- full = (count==DEPTH); empty = (count==0).
- Bypass (combinational):
  - Search all valid queue entries plus the output register when r_write=1.
  - Hit when the entry addr equals the lookup addr and the lookup addr != 0.
  - With multiple matches, the youngest wins: tail-most queue entry first, then older entries, and the output register is oldest.
  - Entries being enqueued in the current cycle are not visible until the next cycle.
  - fwd_data = 0 when there is no hit.
- Same address written twice: both writes are emitted in order; the register file ends with the younger value.

Test Plan:
- Reset mid-operation: enqueue 3 entries, assert reset asynchronously between edges → count=0, r_write=0, rd_addr=0, rd_w_data=0 immediately; no writes issued after release.
- Single write latency: ld_valid with ld_addr=5, ld_data=0x000000AA accepted at edge N → r_write=1, rd_addr=5, rd_w_data=0xAA between edges N+1 and N+2; r_write=0 afterwards.
- Arbitration: ld_valid and alu_valid high together (ld_addr=3/0x11, alu_addr=4/0x22) → ld accepted first and alu_ready=0 that cycle; ALU accepted next cycle; writes emitted in order reg 3 then reg 4.
- Backpressure and full: hold r_write path busy by pushing 1 per cycle from both sources for 10 cycles; with DEPTH=4, count never exceeds 4, ld_ready=0 whenever count==4, and all accepted entries are written exactly once in acceptance order.
- Register 0 drop: ld_addr=0, ld_data=0xFFFFFFFF with ld_valid → ld_ready=1, count stays 0, no r_write pulse; rs_addr=0 → rs_fwd_hit=0.
- Bypass youngest-wins: enqueue reg 7=0x1, then reg 7=0x2 while stalled behind other entries; rs_addr=7 → rs_fwd_hit=1, rs_fwd_data=0x2; after both retire, hit=0 and fwd_data=0.
